// File: rtl/mem_if_pkg.sv
// Shared definitions for the word-wide memory access controller:
// request size codes, the controller state encoding and the alignment rule.
package mem_if_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  // ST_ERR is a one-cycle stop for rejected requests on their way to ST_RESP.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WR_ISSUE,
    ST_ERR,
    ST_RESP
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = lane[0];
      SIZE_WORD: bad = |lane;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: load extraction with sign/zero extension, and the
// read-modify-write merge of sub-word store data into a fetched word.
module mem_lane_align
  import mem_if_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        zext_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = word_i[8*lane_i +: 8];
    halfSel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SIZE_BYTE: load_o = {{24{~zext_i & byteSel[7]}}, byteSel};
      SIZE_HALF: load_o = {{16{~zext_i & halfSel[15]}}, halfSel};
      default:   load_o = word_i;
    endcase
  end

  // Untouched lanes keep the bytes fetched from memory.
  always_comb begin
    merge_o = word_i;
    case (size_i)
      SIZE_BYTE: merge_o[8*lane_i +: 8] = wdata_i[7:0];
      SIZE_HALF: begin
        if (lane_i[1]) merge_o[31:16] = wdata_i[15:0];
        else           merge_o[15:0]  = wdata_i[15:0];
      end
      default:   merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store front end for the word-wide memory command interface: aligns
// sub-word loads, performs read-modify-write for sub-word stores, rejects misalignment.
module mem_access_ctrl
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_misaligned,
  output logic              mem_cmd_start,
  output logic              mem_cmd_write,
  input  logic              mem_cmd_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid,
  output logic [DATA_W-1:0] mem_wdata
);

  state_e            state_q;
  logic              write_q;
  logic [1:0]        size_q;
  logic              zext_q;
  logic [1:0]        lane_q;
  logic [DATA_W-1:0] wdata_q;

  logic              reqReady_q;
  logic              respValid_q;
  logic [DATA_W-1:0] respRdata_q;
  logic              respMis_q;
  logic              cmdStart_q;
  logic              cmdWrite_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [DATA_W-1:0] memWdata_q;

  logic [DATA_W-1:0] loadVal;
  logic [DATA_W-1:0] mergeVal;

  mem_lane_align u_align (
    .word_i  (mem_rdata),
    .wdata_i (wdata_q),
    .lane_i  (lane_q),
    .size_i  (size_q),
    .zext_i  (zext_q),
    .load_o  (loadVal),
    .merge_o (mergeVal)
  );

  // The fetched word is consumed in the cycle it arrives, so no copy of it is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      size_q      <= SIZE_BYTE;
      zext_q      <= 1'b0;
      lane_q      <= '0;
      wdata_q     <= '0;
      reqReady_q  <= 1'b1;
      respValid_q <= 1'b0;
      respRdata_q <= '0;
      respMis_q   <= 1'b0;
      cmdStart_q  <= 1'b0;
      cmdWrite_q  <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
    end else begin
      respValid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            reqReady_q <= 1'b0;
            write_q    <= req_write;
            size_q     <= req_size;
            zext_q     <= req_unsigned;
            lane_q     <= req_addr[1:0];
            wdata_q    <= req_wdata;
            memAddr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
            if (is_misaligned(req_size, req_addr[1:0])) begin
              state_q <= ST_ERR;
            end else if (req_write && (req_size == SIZE_WORD)) begin
              state_q    <= ST_WR_ISSUE;
              cmdStart_q <= 1'b1;
              cmdWrite_q <= 1'b1;
              memWdata_q <= req_wdata;
            end else begin
              state_q    <= ST_RD_ISSUE;
              cmdStart_q <= 1'b1;
              cmdWrite_q <= 1'b0;
            end
          end
        end
        ST_RD_ISSUE: begin
          if (mem_cmd_ready) begin
            cmdStart_q <= 1'b0;
            state_q    <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (mem_rdata_valid) begin
            if (write_q) begin
              state_q    <= ST_WR_ISSUE;
              cmdStart_q <= 1'b1;
              cmdWrite_q <= 1'b1;
              memWdata_q <= mergeVal;
            end else begin
              state_q     <= ST_RESP;
              respValid_q <= 1'b1;
              respRdata_q <= loadVal;
            end
          end
        end
        ST_WR_ISSUE: begin
          if (mem_cmd_ready) begin
            cmdStart_q  <= 1'b0;
            cmdWrite_q  <= 1'b0;
            state_q     <= ST_RESP;
            respValid_q <= 1'b1;
            respRdata_q <= '0;
          end
        end
        ST_ERR: begin
          state_q     <= ST_RESP;
          respValid_q <= 1'b1;
          respMis_q   <= 1'b1;
          respRdata_q <= '0;
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          reqReady_q  <= 1'b1;
          respMis_q   <= 1'b0;
          respRdata_q <= '0;
        end
        default: begin
          state_q    <= ST_IDLE;
          reqReady_q <= 1'b1;
          cmdStart_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready       = reqReady_q;
  assign resp_valid      = respValid_q;
  assign resp_rdata      = respRdata_q;
  assign resp_misaligned = respMis_q;
  assign mem_cmd_start   = cmdStart_q;
  assign mem_cmd_write   = cmdWrite_q;
  assign mem_addr        = memAddr_q;
  assign mem_wdata       = memWdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: behavioural word memory with stall
// knobs, a response scoreboard, a vector table and hand-written corner sequences.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        mem_cmd_start;
  logic        mem_cmd_write;
  logic        mem_cmd_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic [31:0] mem_wdata;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .mem_cmd_start   (mem_cmd_start),
    .mem_cmd_write   (mem_cmd_write),
    .mem_cmd_ready   (mem_cmd_ready),
    .mem_addr        (mem_addr),
    .mem_rdata       (mem_rdata),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_wdata       (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          doPre;
    logic [31:0] pre;
    bit          wr;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRd;
    bit          expMis;
    int          expLat;
    logic [31:0] expMem;
    int          expCmds;
    int          expWrites;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    bit          mis;
  } resp_t;

  int tests = 0;
  int fails = 0;

  resp_t expQ[$];
  vec_t  vecs[$];

  logic [31:0] memArr[64];
  int          stallLeft = 0;
  int          validDelay = 0;
  int          startCycles = 0;
  int          writeCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural memory: decides ready on the falling edge, and acts on a command
  // at the falling edge after the rising edge that accepted it.
  initial begin
    bit          accepted;
    bit          accWrite;
    logic [31:0] accAddr;
    logic [31:0] accWdata;
    bit          pendingRead;
    logic [31:0] readAddr;
    int          validCnt;
    bit          stallActive;
    logic [31:0] heldAddr;
    logic [31:0] heldWdata;
    bit          heldWrite;
    accepted = 0; accWrite = 0; accAddr = '0; accWdata = '0;
    pendingRead = 0; readAddr = '0; validCnt = 0; stallActive = 0;
    heldAddr = '0; heldWdata = '0; heldWrite = 0;
    for (int i = 0; i < 64; i++) memArr[i] = '0;
    mem_cmd_ready   = 1'b0;
    mem_rdata_valid = 1'b0;
    mem_rdata       = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        accepted = 0; pendingRead = 0; stallActive = 0; stallLeft = 0;
        mem_cmd_ready = 1'b0;
        mem_rdata_valid = 1'b0;
      end else begin
        if (accepted) begin
          if (accWrite) begin
            memArr[accAddr[7:2]] = accWdata;
            writeCount++;
          end else begin
            pendingRead = 1;
            readAddr    = accAddr;
            validCnt    = validDelay;
          end
          accepted = 0;
        end
        mem_rdata_valid = 1'b0;
        if (pendingRead) begin
          if (validCnt == 0) begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = memArr[readAddr[7:2]];
            pendingRead     = 0;
          end else begin
            validCnt--;
          end
        end
        if (mem_cmd_start) begin
          startCycles++;
          if (stallActive) begin
            checkOutput("stall_addr_stable", mem_addr, heldAddr);
            checkOutput("stall_wdata_stable", mem_wdata, heldWdata);
            checkOutput("stall_write_stable", {31'd0, mem_cmd_write}, {31'd0, heldWrite});
          end
          if (stallLeft > 0) begin
            mem_cmd_ready = 1'b0;
            stallLeft--;
            if (!stallActive) begin
              heldAddr  = mem_addr;
              heldWdata = mem_wdata;
              heldWrite = mem_cmd_write;
            end
            stallActive = 1;
          end else begin
            mem_cmd_ready = 1'b1;
            stallActive   = 0;
            accepted      = 1;
            accWrite      = mem_cmd_write;
            accAddr       = mem_addr;
            accWdata      = mem_wdata;
          end
        end else begin
          mem_cmd_ready = 1'b0;
        end
      end
    end
  end

  // Scoreboard consumer: every response pulse must match the oldest expectation.
  initial begin
    resp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && resp_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("resp_rdata", resp_rdata, e.rdata);
          checkOutput("resp_misaligned", {31'd0, resp_misaligned}, {31'd0, e.mis});
        end
      end
    end
  end

  function automatic vec_t mkVec(bit doPre, logic [31:0] pre, bit wr, logic [1:0] size, bit uns,
                                 logic [31:0] addr, logic [31:0] wdata, logic [31:0] expRd,
                                 bit expMis, int expLat, logic [31:0] expMem, int expCmds,
                                 int expWrites, string name);
    vec_t v;
    v.doPre = doPre; v.pre = pre; v.wr = wr; v.size = size; v.uns = uns;
    v.addr = addr; v.wdata = wdata; v.expRd = expRd; v.expMis = expMis;
    v.expLat = expLat; v.expMem = expMem; v.expCmds = expCmds;
    v.expWrites = expWrites; v.name = name;
    return v;
  endfunction

  task automatic waitReady(input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    if (!ok) checkOutput({name, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic driveReq(input vec_t v);
    resp_t r;
    req_valid    = 1'b1;
    req_write    = v.wr;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    r.rdata = v.expRd;
    r.mis   = v.expMis;
    expQ.push_back(r);
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_write    = ~v.wr;
    req_size     = ~v.size;
    req_unsigned = ~v.uns;
    req_addr     = ~v.addr;
    req_wdata    = ~v.wdata;
  endtask

  // Latency is counted to the rising edge that samples the response pulse.
  task automatic applyStimulus(input vec_t v);
    int startsBefore;
    int writesBefore;
    int lat;
    bit ok;
    if (v.doPre) memArr[v.addr[7:2]] = v.pre;
    waitReady(v.name, ok);
    if (ok) begin
      startsBefore = startCycles;
      writesBefore = writeCount;
      driveReq(v);
      lat = 0;
      for (int c = 1; c <= 60 && lat == 0; c++) begin
        @(posedge clk);
        #1;
        if (resp_valid) lat = c + 1;
      end
      if (lat == 0) expQ.delete();
      checkOutput({v.name, "_latency"}, lat, v.expLat);
      @(negedge clk);
      #1;
      checkOutput({v.name, "_start_cycles"}, startCycles - startsBefore, v.expCmds);
      checkOutput({v.name, "_writes"}, writeCount - writesBefore, v.expWrites);
      checkOutput({v.name, "_mem_word"}, memArr[v.addr[7:2]], v.expMem);
    end
  endtask

  initial begin
    bit   ok;
    vec_t v;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;

    vecs.push_back(mkVec(0, 32'h0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 32'hDEADBEEF, 1, 1, "sw_10"));
    vecs.push_back(mkVec(0, 32'h0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 32'hDEADBEEF, 1, 0, "lw_10"));
    vecs.push_back(mkVec(1, 32'h11223344, 0, 2'b00, 0, 32'h23, 32'h0, 32'h00000011, 0, 3, 32'h11223344, 1, 0, "lb_23"));
    vecs.push_back(mkVec(0, 32'h0, 0, 2'b00, 0, 32'h21, 32'h0, 32'h00000033, 0, 3, 32'h11223344, 1, 0, "lb_21"));
    vecs.push_back(mkVec(0, 32'h0, 0, 2'b01, 0, 32'h22, 32'h0, 32'h00001122, 0, 3, 32'h11223344, 1, 0, "lh_22"));
    vecs.push_back(mkVec(1, 32'h80FF0000, 0, 2'b00, 0, 32'h22, 32'h0, 32'hFFFFFFFF, 0, 3, 32'h80FF0000, 1, 0, "lb_22_neg"));
    vecs.push_back(mkVec(0, 32'h0, 0, 2'b00, 1, 32'h22, 32'h0, 32'h000000FF, 0, 3, 32'h80FF0000, 1, 0, "lbu_22"));
    vecs.push_back(mkVec(0, 32'h0, 0, 2'b01, 0, 32'h22, 32'h0, 32'hFFFF80FF, 0, 3, 32'h80FF0000, 1, 0, "lh_22_neg"));
    vecs.push_back(mkVec(1, 32'h11223344, 1, 2'b00, 0, 32'h21, 32'hFFFFFFAA, 32'h0, 0, 4, 32'h1122AA44, 2, 1, "sb_21"));
    vecs.push_back(mkVec(0, 32'h0, 1, 2'b01, 0, 32'h22, 32'hFFFFBEEF, 32'h0, 0, 4, 32'hBEEFAA44, 2, 1, "sh_22"));
    vecs.push_back(mkVec(0, 32'h0, 0, 2'b10, 0, 32'h22, 32'h0, 32'h0, 1, 2, 32'hBEEFAA44, 0, 0, "lw_22_mis"));
    vecs.push_back(mkVec(1, 32'h01020304, 1, 2'b01, 0, 32'h01, 32'h00001234, 32'h0, 1, 2, 32'h01020304, 0, 0, "sh_01_mis"));
    vecs.push_back(mkVec(0, 32'h0, 0, 2'b11, 0, 32'h20, 32'h0, 32'h0, 1, 2, 32'hBEEFAA44, 0, 0, "size11_mis"));
    vecs.push_back(mkVec(1, 32'h80018000, 0, 2'b01, 0, 32'h20, 32'h0, 32'hFFFF8000, 0, 3, 32'h80018000, 1, 0, "lh_20_neg"));
    vecs.push_back(mkVec(0, 32'h0, 0, 2'b01, 1, 32'h22, 32'h0, 32'h00008001, 0, 3, 32'h80018000, 1, 0, "lhu_22"));
    vecs.push_back(mkVec(1, 32'hAABBCCDD, 1, 2'b00, 0, 32'h23, 32'h12345678, 32'h0, 0, 4, 32'h78BBCCDD, 2, 1, "sb_23"));
    vecs.push_back(mkVec(0, 32'h0, 0, 2'b00, 0, 32'h20, 32'h0, 32'hFFFFFFDD, 0, 3, 32'h78BBCCDD, 1, 0, "lb_20_neg"));
    vecs.push_back(mkVec(0, 32'h0, 1, 2'b10, 0, 32'h24, 32'h0BADF00D, 32'h0, 0, 2, 32'h0BADF00D, 1, 1, "sw_24"));

    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("reset_resp_rdata", resp_rdata, 32'd0);
    checkOutput("reset_resp_mis", {31'd0, resp_misaligned}, 32'd0);
    checkOutput("reset_cmd_start", {31'd0, mem_cmd_start}, 32'd0);
    checkOutput("reset_cmd_write", {31'd0, mem_cmd_write}, 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'd0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Stalled command acceptance plus late read data: load latency 3 + 3 + 2.
    stallLeft  = 3;
    validDelay = 2;
    applyStimulus(mkVec(1, 32'hCAFEF00D, 0, 2'b10, 0, 32'h10, 32'h0, 32'hCAFEF00D, 0, 8, 32'hCAFEF00D, 4, 0, "lw_stall"));
    stallLeft = 3;
    applyStimulus(mkVec(0, 32'h0, 1, 2'b10, 0, 32'h14, 32'h12345678, 32'h0, 0, 5, 32'h12345678, 4, 1, "sw_stall"));
    validDelay = 0;

    // Reset while a read command is being held by a stalled memory.
    memArr[8] = 32'h55667788;
    waitReady("rst_issue", ok);
    if (ok) begin
      stallLeft = 5;
      driveReq(mkVec(0, 32'h0, 0, 2'b10, 0, 32'h20, 32'h0, 32'h55667788, 0, 0, 32'h0, 0, 0, "rst_issue"));
      @(negedge clk);
      checkOutput("rst_issue_start_before", {31'd0, mem_cmd_start}, 32'd1);
      rst_n = 1'b0;
      #1;
      expQ.delete();
      checkOutput("rst_issue_start_drops", {31'd0, mem_cmd_start}, 32'd0);
      checkOutput("rst_issue_req_ready", {31'd0, req_ready}, 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end

    // Reset while waiting for read data: the response must never appear.
    validDelay = 10;
    waitReady("rst_wait", ok);
    if (ok) begin
      driveReq(mkVec(0, 32'h0, 0, 2'b10, 0, 32'h20, 32'h0, 32'h55667788, 0, 0, 32'h0, 0, 0, "rst_wait"));
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      expQ.delete();
      checkOutput("rst_wait_start", {31'd0, mem_cmd_start}, 32'd0);
      checkOutput("rst_wait_resp_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("rst_wait_req_ready", {31'd0, req_ready}, 32'd1);
      repeat (3) @(negedge clk);
      validDelay = 0;
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
    end
    v = mkVec(0, 32'h0, 0, 2'b10, 0, 32'h20, 32'h0, 32'h55667788, 0, 3, 32'h55667788, 1, 0, "lw_after_rst");
    applyStimulus(v);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", expQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
